// File: rtl/sat_engine_ctrl.sv
// sat_engine_ctrl: initiator-side sequencer for the sat engine state list (load, propagate, decide/imply/analyze/backtrack loop)
// Ports: clk/rst (sync, active-high); start_core_i, cur_bin_num_i, base_lvl_i start a run;
//   load_lvl_en_o/load_lvl_o, base_lvl_en_o/base_lvl_o load the latched base level;
//   start_decision_o/done_decision_i/decision_none_i, apply_imply_o/done_imply_i/find_conflict_i,
//   apply_analyze_o/done_analyze_i/bkt_bin_i/bkt_lvl_i, apply_bkt_cur_bin_o/done_bkt_cur_bin_i are the state list handshakes;
//   done_core_o, result_o (0 none, 1 SAT, 2 UNSAT, 3 other bin), bkt_bin_o, bkt_lvl_o, num_decisions_o, num_conflicts_o, error_o report the run.
// Optional: define SAT_CTRL_WATCHDOG_EN to abort a run when a done_* does not arrive within WATCHDOG_CYCLES.
module sat_engine_ctrl #(
   parameter int WIDTH_LVL    = 16,
   parameter int WIDTH_BIN_ID = 10,
   parameter int WIDTH_CNT    = 16
`ifdef SAT_CTRL_WATCHDOG_EN
  ,parameter int WATCHDOG_CYCLES = 1024
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_core_i,
   input  logic [WIDTH_BIN_ID-1:0] cur_bin_num_i,
   input  logic [WIDTH_LVL-1:0]    base_lvl_i,
   output logic                    load_lvl_en_o,
   output logic [WIDTH_LVL-1:0]    load_lvl_o,
   output logic                    base_lvl_en_o,
   output logic [WIDTH_LVL-1:0]    base_lvl_o,
   output logic                    start_decision_o,
   input  logic                    done_decision_i,
   input  logic                    decision_none_i,
   output logic                    apply_imply_o,
   input  logic                    done_imply_i,
   input  logic                    find_conflict_i,
   output logic                    apply_analyze_o,
   input  logic                    done_analyze_i,
   input  logic [WIDTH_BIN_ID-1:0] bkt_bin_i,
   input  logic [WIDTH_LVL-1:0]    bkt_lvl_i,
   output logic                    apply_bkt_cur_bin_o,
   input  logic                    done_bkt_cur_bin_i,
   output logic                    done_core_o,
   output logic [1:0]              result_o,
   output logic [WIDTH_BIN_ID-1:0] bkt_bin_o,
   output logic [WIDTH_LVL-1:0]    bkt_lvl_o,
   output logic [WIDTH_CNT-1:0]    num_decisions_o,
   output logic [WIDTH_CNT-1:0]    num_conflicts_o,
   output logic                    error_o
);
   localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_DECIDE = 3'd2, S_IMPLY = 3'd3,
                          S_ANALYZE = 3'd4, S_ANA_REL = 3'd5, S_BKT = 3'd6, S_FINISH = 3'd7;
   localparam logic [1:0] RES_SAT = 2'd1, RES_UNSAT = 2'd2, RES_OTHER = 2'd3;
   logic [2:0] r_state;
   logic       w_timeout;
   assign load_lvl_o = base_lvl_o;
`ifdef SAT_CTRL_WATCHDOG_EN
   localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
   logic [WW-1:0] r_wd;
   logic          w_wait;
   // Any matching done_* ends the wait, so clearing while not waiting equals clearing on entry to the next wait state.
   assign w_wait = (r_state == S_DECIDE && !done_decision_i) || (r_state == S_IMPLY && !done_imply_i) ||
                   (r_state == S_ANALYZE && !done_analyze_i) || (r_state == S_BKT && !done_bkt_cur_bin_i);
   assign w_timeout = w_wait && r_wd == WW'(WATCHDOG_CYCLES - 1);
   always_ff @(posedge clk)
      r_wd <= (rst || !w_wait) ? '0 : r_wd + 1'b1;
`else
   assign w_timeout = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state             <= S_IDLE;
         load_lvl_en_o       <= 1'b0;
         base_lvl_en_o       <= 1'b0;
         base_lvl_o          <= '0;
         start_decision_o    <= 1'b0;
         apply_imply_o       <= 1'b0;
         apply_analyze_o     <= 1'b0;
         apply_bkt_cur_bin_o <= 1'b0;
         done_core_o         <= 1'b0;
         result_o            <= '0;
         bkt_bin_o           <= '0;
         bkt_lvl_o           <= '0;
         num_decisions_o     <= '0;
         num_conflicts_o     <= '0;
         error_o             <= 1'b0;
      end else begin
         load_lvl_en_o    <= 1'b0;
         base_lvl_en_o    <= 1'b0;
         start_decision_o <= 1'b0;
         done_core_o      <= 1'b0;
         if (w_timeout) begin
            apply_imply_o       <= 1'b0;
            apply_analyze_o     <= 1'b0;
            apply_bkt_cur_bin_o <= 1'b0;
            error_o             <= 1'b1;
            result_o            <= '0;
            done_core_o         <= 1'b1;
            r_state             <= S_FINISH;
         end else begin
            case (r_state)
               S_IDLE: if (start_core_i) begin
                  base_lvl_o      <= base_lvl_i;
                  num_decisions_o <= '0;
                  num_conflicts_o <= '0;
                  result_o        <= '0;
                  error_o         <= 1'b0;
                  bkt_bin_o       <= '0;
                  bkt_lvl_o       <= '0;
                  load_lvl_en_o   <= 1'b1;
                  base_lvl_en_o   <= 1'b1;
                  r_state         <= S_LOAD;
               end
               S_LOAD: begin
                  apply_imply_o <= 1'b1;
                  r_state       <= S_IMPLY;
               end
               S_DECIDE: if (done_decision_i) begin
                  if (decision_none_i) begin
                     result_o    <= RES_SAT;
                     done_core_o <= 1'b1;
                     r_state     <= S_FINISH;
                  end else begin
                     num_decisions_o <= num_decisions_o + {{(WIDTH_CNT-1){1'b0}}, ~&num_decisions_o};
                     apply_imply_o   <= 1'b1;
                     r_state         <= S_IMPLY;
                  end
               end
               S_IMPLY: if (done_imply_i) begin
                  apply_imply_o <= 1'b0;
                  if (find_conflict_i) begin
                     num_conflicts_o <= num_conflicts_o + {{(WIDTH_CNT-1){1'b0}}, ~&num_conflicts_o};
                     apply_analyze_o <= 1'b1;
                     r_state         <= S_ANALYZE;
                  end else begin
                     start_decision_o <= 1'b1;
                     r_state          <= S_DECIDE;
                  end
               end
               S_ANALYZE: if (done_analyze_i) begin
                  apply_analyze_o <= 1'b0;
                  bkt_bin_o       <= bkt_bin_i;
                  bkt_lvl_o       <= bkt_lvl_i;
                  r_state         <= S_ANA_REL;
               end
               S_ANA_REL: begin
                  // Level 0 means nothing left to undo, so UNSAT outranks a foreign target bin.
                  if (bkt_lvl_o == '0 || bkt_bin_o != cur_bin_num_i) begin
                     result_o    <= (bkt_lvl_o == '0) ? RES_UNSAT : RES_OTHER;
                     done_core_o <= 1'b1;
                     r_state     <= S_FINISH;
                  end else begin
                     apply_bkt_cur_bin_o <= 1'b1;
                     r_state             <= S_BKT;
                  end
               end
               S_BKT: if (done_bkt_cur_bin_i) begin
                  apply_bkt_cur_bin_o <= 1'b0;
                  apply_imply_o       <= 1'b1;
                  r_state             <= S_IMPLY;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_sat_engine_ctrl.sv
// tb_sat_engine_ctrl: randomized responder bench for sat_engine_ctrl with a run-level reference model
module tb_sat_engine_ctrl;
   localparam int P_IMPLY = 0, P_DEC = 1, P_ANA = 2, P_BKT = 3;
   logic        clk = 1'b0;
   logic        rst;
   logic        start_core_i;
   logic [9:0]  cur_bin_num_i;
   logic [15:0] base_lvl_i;
   logic        load_lvl_en_o;
   logic [15:0] load_lvl_o;
   logic        base_lvl_en_o;
   logic [15:0] base_lvl_o;
   logic        start_decision_o;
   logic        done_decision_i;
   logic        decision_none_i;
   logic        apply_imply_o;
   logic        done_imply_i;
   logic        find_conflict_i;
   logic        apply_analyze_o;
   logic        done_analyze_i;
   logic [9:0]  bkt_bin_i;
   logic [15:0] bkt_lvl_i;
   logic        apply_bkt_cur_bin_o;
   logic        done_bkt_cur_bin_i;
   logic        done_core_o;
   logic [1:0]  result_o;
   logic [9:0]  bkt_bin_o;
   logic [15:0] bkt_lvl_o;
   logic [15:0] num_decisions_o;
   logic [15:0] num_conflicts_o;
   logic        error_o;
   int checks = 0;
   int errors = 0;
   sat_engine_ctrl dut (
      .clk(clk), .rst(rst), .start_core_i(start_core_i), .cur_bin_num_i(cur_bin_num_i), .base_lvl_i(base_lvl_i),
      .load_lvl_en_o(load_lvl_en_o), .load_lvl_o(load_lvl_o), .base_lvl_en_o(base_lvl_en_o), .base_lvl_o(base_lvl_o),
      .start_decision_o(start_decision_o), .done_decision_i(done_decision_i), .decision_none_i(decision_none_i),
      .apply_imply_o(apply_imply_o), .done_imply_i(done_imply_i), .find_conflict_i(find_conflict_i),
      .apply_analyze_o(apply_analyze_o), .done_analyze_i(done_analyze_i), .bkt_bin_i(bkt_bin_i), .bkt_lvl_i(bkt_lvl_i),
      .apply_bkt_cur_bin_o(apply_bkt_cur_bin_o), .done_bkt_cur_bin_i(done_bkt_cur_bin_i), .done_core_o(done_core_o),
      .result_o(result_o), .bkt_bin_o(bkt_bin_o), .bkt_lvl_o(bkt_lvl_o), .num_decisions_o(num_decisions_o),
      .num_conflicts_o(num_conflicts_o), .error_o(error_o)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask
   function automatic logic any_out();
      return |{load_lvl_en_o, load_lvl_o, base_lvl_en_o, base_lvl_o, start_decision_o, apply_imply_o, apply_analyze_o,
               apply_bkt_cur_bin_o, done_core_o, result_o, bkt_bin_o, bkt_lvl_o, num_decisions_o, num_conflicts_o, error_o};
   endfunction
   task automatic clr_in();
      start_core_i = 1'b0; done_decision_i = 1'b0; decision_none_i = 1'b0; done_imply_i = 1'b0; find_conflict_i = 1'b0;
      done_analyze_i = 1'b0; done_bkt_cur_bin_i = 1'b0;
   endtask
   // Acts as the state list: answers each request after a random delay, injects stray inputs, and predicts the run outcome.
   task automatic run(input logic [15:0] base, input logic [9:0] bin, input int max_steps);
      int dec = 0, con = 0, steps = 0, phase = P_IMPLY, k;
      logic [1:0] res = 2'd0;
      logic [9:0] bb = '0, b;
      logic [15:0] bl = '0, l;
      bit fin = 1'b0, c, n;
      cur_bin_num_i = bin; base_lvl_i = base; start_core_i = 1'b1;
      @(negedge clk);
      start_core_i = 1'b0; base_lvl_i = 16'(base + 16'd1);
      chk("load_en", 32'(load_lvl_en_o), 1);
      chk("base_en", 32'(base_lvl_en_o), 1);
      chk("load_lvl", 32'(load_lvl_o), 32'(base));
      chk("base_lvl", 32'(base_lvl_o), 32'(base));
      chk("start_clr", 32'({result_o, num_decisions_o, num_conflicts_o, bkt_bin_o, bkt_lvl_o, error_o}), 0);
      @(negedge clk);
      chk("load_en_drop", 32'({load_lvl_en_o, base_lvl_en_o}), 0);
      while (!fin) begin
         steps++;
         case (phase)
            P_IMPLY: begin
               chk("imply_req", 32'(apply_imply_o), 1);
               repeat ($urandom_range(0, 2)) begin
                  start_core_i = 1'b1; done_decision_i = 1'($urandom_range(0, 1));
                  @(negedge clk);
                  clr_in();
                  chk("imply_hold", 32'(apply_imply_o), 1);
               end
               c = (steps < max_steps) && ($urandom_range(0, 2) == 0);
               done_imply_i = 1'b1; find_conflict_i = c;
               @(negedge clk);
               clr_in();
               chk("imply_drop", 32'(apply_imply_o), 0);
               if (c) begin con++; phase = P_ANA; end else phase = P_DEC;
            end
            P_DEC: begin
               chk("dec_pulse", 32'(start_decision_o), 1);
               repeat ($urandom_range(0, 2)) begin
                  done_analyze_i = 1'b1; done_bkt_cur_bin_i = 1'b1;
                  @(negedge clk);
                  clr_in();
                  chk("dec_once", 32'(start_decision_o), 0);
                  chk("dec_stray", 32'({apply_analyze_o, apply_bkt_cur_bin_o, done_core_o}), 0);
               end
               n = (steps >= max_steps) || ($urandom_range(0, 3) == 0);
               done_decision_i = 1'b1; decision_none_i = n;
               done_imply_i = 1'($urandom_range(0, 1)); find_conflict_i = 1'b1;
               @(negedge clk);
               clr_in();
               chk("dec_drop", 32'(start_decision_o), 0);
               if (n) begin res = 2'd1; fin = 1'b1; end else begin dec++; phase = P_IMPLY; end
            end
            P_ANA: begin
               chk("ana_req", 32'(apply_analyze_o), 1);
               repeat ($urandom_range(0, 2)) begin
                  done_imply_i = 1'b1; find_conflict_i = 1'b1; done_decision_i = 1'b1;
                  @(negedge clk);
                  clr_in();
                  chk("ana_hold", 32'(apply_analyze_o), 1);
                  chk("ana_cnt", 32'(num_conflicts_o), 32'(con));
               end
               k = (steps >= max_steps) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
               l = (k == 0) ? 16'd0 : 16'($urandom_range(1, 200));
               b = (k == 1) ? 10'(bin + 10'($urandom_range(1, 5))) : (k == 0) ? 10'($urandom_range(0, 7)) : bin;
               done_analyze_i = 1'b1; bkt_bin_i = b; bkt_lvl_i = l;
               @(negedge clk);
               clr_in();
               bkt_bin_i = 10'($urandom); bkt_lvl_i = 16'($urandom);
               bb = b; bl = l;
               chk("ana_rel", 32'(apply_analyze_o), 0);
               chk("bkt_bin_cap", 32'(bkt_bin_o), 32'(b));
               chk("bkt_lvl_cap", 32'(bkt_lvl_o), 32'(l));
               @(negedge clk);
               if (l == 16'd0) begin res = 2'd2; fin = 1'b1; end
               else if (b != bin) begin res = 2'd3; fin = 1'b1; end
               else phase = P_BKT;
               if (fin) chk("no_bkt", 32'(apply_bkt_cur_bin_o), 0);
            end
            default: begin
               chk("bkt_req", 32'(apply_bkt_cur_bin_o), 1);
               repeat ($urandom_range(0, 2)) begin
                  done_analyze_i = 1'b1; done_imply_i = 1'b1;
                  @(negedge clk);
                  clr_in();
                  chk("bkt_hold", 32'(apply_bkt_cur_bin_o), 1);
                  chk("bkt_keep", 32'(bkt_bin_o), 32'(bb));
               end
               done_bkt_cur_bin_i = 1'b1;
               @(negedge clk);
               clr_in();
               chk("bkt_drop", 32'(apply_bkt_cur_bin_o), 0);
               phase = P_IMPLY;
            end
         endcase
      end
      chk("done_core", 32'(done_core_o), 1);
      chk("result", 32'(result_o), 32'(res));
      chk("num_dec", 32'(num_decisions_o), 32'(dec));
      chk("num_con", 32'(num_conflicts_o), 32'(con));
      chk("bkt_bin_out", 32'(bkt_bin_o), 32'(bb));
      chk("bkt_lvl_out", 32'(bkt_lvl_o), 32'(bl));
      chk("base_kept", 32'(base_lvl_o), 32'(base));
      chk("fin_quiet", 32'({apply_imply_o, apply_analyze_o, apply_bkt_cur_bin_o, start_decision_o, error_o}), 0);
      @(negedge clk);
      chk("done_once", 32'(done_core_o), 0);
      chk("result_held", 32'(result_o), 32'(res));
   endtask
   initial begin
      rst = 1'b1; clr_in(); cur_bin_num_i = '0; base_lvl_i = '0; bkt_bin_i = '0; bkt_lvl_i = '0;
      repeat (2) @(negedge clk);
      chk("reset_outs", 32'(any_out()), 0);
      rst = 1'b0;
      @(negedge clk);
      cur_bin_num_i = 10'd4; base_lvl_i = 16'd9; start_core_i = 1'b1;
      @(negedge clk);
      start_core_i = 1'b0;
      @(negedge clk);
      chk("pre_rst_imply", 32'(apply_imply_o), 1);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_outs", 32'(any_out()), 0);
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_idle", 32'(any_out()), 0);
      end
      run(16'd5, 10'd4, 6);
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            chk("idle_quiet", 32'({done_core_o, apply_imply_o, start_decision_o, load_lvl_en_o}), 0);
         end
         run(16'($urandom_range(1, 1000)), 10'($urandom_range(1, 6)), int'($urandom_range(2, 12)));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sat_engine_ctrl.md
Name: sat_engine_ctrl

Overview:
Initiator-side sequencer for the sat engine state list. It drives the decide / imply / analyze / backtrack handshakes that the state list answers, and reports one result per bin run to the bin manager. One run is: load levels, propagate, then loop decide → imply → (analyze → backtrack). The run ends with SAT, UNSAT, or "backtrack to another bin".

Parameters:
WIDTH_LVL, 16, level width (matches state list)
WIDTH_BIN_ID, 10, bin id width
WIDTH_CNT, 16, width of decision/conflict statistics counters
WATCHDOG_CYCLES, 1024, max cycles waiting for any done_* (only with optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start_core_i  in  1  one-cycle pulse; begin a run on the current bin
cur_bin_num_i  in  WIDTH_BIN_ID  id of bin being solved
base_lvl_i  in  WIDTH_LVL  base level of this bin, sampled with start_core_i
load_lvl_en_o  out  1  pulse: load cur level into decision unit
load_lvl_o  out  WIDTH_LVL  level to load (= latched base_lvl)
base_lvl_en_o  out  1  pulse: load base level into state list
base_lvl_o  out  WIDTH_LVL  latched base level
start_decision_o  out  1  one-cycle decision pulse
done_decision_i  in  1  decision finished
decision_none_i  in  1  no free variable; valid with done_decision_i
apply_imply_o  out  1  level, held until done_imply_i
done_imply_i  in  1  implication fixpoint or conflict reached
find_conflict_i  in  1  conflict flag, sampled with done_imply_i
apply_analyze_o  out  1  level, held until done_analyze_i
done_analyze_i  in  1  analysis done
bkt_bin_i  in  WIDTH_BIN_ID  target bin, valid with done_analyze_i
bkt_lvl_i  in  WIDTH_LVL  target level, valid with done_analyze_i
apply_bkt_cur_bin_o  out  1  level, held until done_bkt_cur_bin_i
done_bkt_cur_bin_i  in  1  in-bin backtrack done
done_core_o  out  1  one-cycle pulse: run finished
result_o  out  2  0 none, 1 SAT, 2 UNSAT, 3 BKT_OTHER_BIN
bkt_bin_o  out  WIDTH_BIN_ID  captured bkt_bin_i
bkt_lvl_o  out  WIDTH_LVL  captured bkt_lvl_i
num_decisions_o  out  WIDTH_CNT  decisions this run, saturating
num_conflicts_o  out  WIDTH_CNT  conflicts this run, saturating
error_o  out  1  watchdog timeout flag

Behaviour:
- Reset:
  - All outputs are 0; FSM is in IDLE.
  - A reset asserted mid-run aborts the run: all outputs are 0 after that edge and no done_core_o is issued.
- Every *_o is registered. The FSM acts on a done_* input in the cycle it is seen high; the resulting output change appears on the next edge.
- IDLE:
  - On start_core_i: latch base_lvl; clear counters, result_o, error_o, bkt_*_o; go to LOAD.
  - start_core_i outside IDLE is ignored.
- LOAD (1 cycle): load_lvl_en_o = base_lvl_en_o = 1; go to IMPLY. The first action of a run is always propagation.
- DECIDE: start_decision_o = 1 for exactly one cycle on entry, then wait.
  - done_decision_i & decision_none_i → FINISH, result SAT.
  - done_decision_i & ~decision_none_i → num_decisions +1, go to IMPLY.
- IMPLY: apply_imply_o = 1 until done_imply_i, dropped the next cycle.
  - find_conflict_i = 1 → num_conflicts +1, go to ANALYZE.
  - Otherwise go to DECIDE.
- ANALYZE: apply_analyze_o = 1 until done_analyze_i; capture bkt_bin_i and bkt_lvl_i on that cycle; go to ANA_REL.
- ANA_REL (1 cycle, apply_analyze_o = 0): lets the responder return to idle. Then, in priority order:
  - bkt_lvl == 0 → FINISH, UNSAT.
  - bkt_bin ≠ cur_bin_num_i → FINISH, BKT_OTHER_BIN.
  - Otherwise → BKT.
- BKT: apply_bkt_cur_bin_o = 1 until done_bkt_cur_bin_i; then go to IMPLY (the learnt clause propagates).
- FINISH (1 cycle): done_core_o = 1; result_o and bkt_*_o stay held until the next start_core_i; go to IDLE.
- Stray done_* inputs in a non-matching state are ignored. done_imply_i asserted together with done_decision_i in DECIDE is ignored.
- Counters saturate at all-ones.

Optional Feature:
SAT_CTRL_WATCHDOG_EN:
- Defined: a wait counter is cleared on entry to DECIDE, IMPLY, ANALYZE, and BKT. If it reaches WATCHDOG_CYCLES without the matching done_*, the FSM drops all apply_*_o, sets error_o = 1 and result_o = 0, and goes to FINISH (done_core_o pulses).
- Undefined: no counter; the FSM waits indefinitely; error_o is tied 0.

Test Plan:
- Reset held for 3 cycles during IMPLY → all outputs 0, FSM in IDLE; a later start_core_i with base_lvl_i=5 → load_lvl_o=5, base_lvl_en_o pulses one cycle later.
- Run with no conflicts: done_imply_i (find_conflict_i=0), two decisions with decision_none_i=0, then decision_none_i=1 → result_o=1, num_decisions_o=2, done_core_o single pulse.
- Conflict with bkt_lvl_i=3, bkt_bin_i=cur_bin_num_i=4 → apply_analyze_o low for ≥1 cycle, then apply_bkt_cur_bin_o high until done, then apply_imply_o high; num_conflicts_o=1.
- Conflict with bkt_bin_i=2, cur_bin_num_i=4, bkt_lvl_i=7 → result_o=3, bkt_bin_o=2, bkt_lvl_o=7; no apply_bkt_cur_bin_o.
- Conflict with bkt_lvl_i=0 → result_o=2; start_core_i during the run ignored; stray done_analyze_i in DECIDE has no effect.
- With SAT_CTRL_WATCHDOG_EN and WATCHDOG_CYCLES=16, done_imply_i never given → apply_imply_o drops after 16 cycles, error_o=1, result_o=0, done_core_o pulses.
